// File: rtl/rf32_pkg.sv
// Shared widths and types for the 32 x 32-bit MIPS register file.
package rf32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf32_read_port.sv
// Combinational read port: a plain mux over the storage array.
// When ZERO_REG is set, address 0 is forced to read zero.
module rf32_read_port
  import rf32_pkg::*;
#(
  parameter int DW       = DATA_WIDTH,
  parameter int AW       = ADDR_WIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] regs [0:(2**AW)-1],
  output logic [DW-1:0] data
);

  always_comb begin
    data = regs[addr];
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/rf32.sv
// Register file: synchronous write and reset, two combinational read ports,
// plus a one-cycle acknowledge of any read or write request.
module rf32
  import rf32_pkg::*;
#(
  parameter int DATA_WIDTH = rf32_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf32_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_enabled,
  input  logic [ADDR_WIDTH-1:0] read_addr_s,
  input  logic [ADDR_WIDTH-1:0] read_addr_t,
  input  logic                  write_enabled,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] outA,
  output logic [DATA_WIDTH-1:0] outB,
  output logic                  finish
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] register_file [0:NUM_REGS-1];
  logic                  write_accept;

  // Writes to r0 are dropped so the stored value itself stays zero.
  assign write_accept = write_enabled && !((ZERO_REG != 0) && (write_addr == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        register_file[i] <= '0;
      end
    end else if (write_accept) begin
      register_file[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      finish <= 1'b0;
    end else begin
      finish <= read_enabled | write_enabled;
    end
  end

  rf32_read_port #(
    .DW       (DATA_WIDTH),
    .AW       (ADDR_WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_port_s (
    .addr (read_addr_s),
    .regs (register_file),
    .data (outA)
  );

  rf32_read_port #(
    .DW       (DATA_WIDTH),
    .AW       (ADDR_WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_port_t (
    .addr (read_addr_t),
    .regs (register_file),
    .data (outB)
  );

endmodule

// File: tb/tb_rf32.sv
// Self-checking bench for rf32 against an array-based reference model.
module tb_rf32;

  logic        clock;
  logic        reset;
  logic        read_enabled;
  logic [4:0]  read_addr_s;
  logic [4:0]  read_addr_t;
  logic        write_enabled;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] outA;
  logic [31:0] outB;
  logic        finish;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  logic        exp_finish;

  rf32 dut (
    .clock         (clock),
    .reset         (reset),
    .read_enabled  (read_enabled),
    .read_addr_s   (read_addr_s),
    .read_addr_t   (read_addr_t),
    .write_enabled (write_enabled),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .outA          (outA),
    .outB          (outB),
    .finish        (finish)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // One clock edge; the model applies the same request the DUT sees at that edge.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_finish = 1'b0;
    end else begin
      if (write_enabled && write_addr != 5'd0) model[write_addr] = write_data;
      exp_finish = read_enabled | write_enabled;
    end
    #1;
  endtask

  task automatic idle_inputs();
    read_enabled  = 1'b0;
    write_enabled = 1'b0;
    write_addr    = 5'd0;
    write_data    = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    read_addr_s = 5'd0;
    read_addr_t = 5'd0;
    tick();
    reset = 1'b0;
    total++;
    if (finish !== 1'b0) begin
      bad++;
      $display("FAIL reset_finish got=%b want=0", finish);
    end
    for (int i = 0; i < 16; i++) begin
      read_addr_s = 5'(2 * i);
      read_addr_t = 5'(2 * i + 1);
      #1;
      total++;
      if (outA !== 32'h0 || outB !== 32'h0) begin
        bad++;
        $display("FAIL reset_read s=%0d t=%0d outA=%h outB=%h want=0", read_addr_s, read_addr_t, outA, outB);
      end
    end
    $display("reset: swept 32 addresses");
  endtask

  task automatic test_write_sweep();
    logic [31:0] v;
    for (int k = 1; k < 32; k++) begin
      if (k <= 16)      v = 32'(k - 1) * 32'h11111111;
      else if (k <= 30) v = 32'(k - 16);
      else              v = 32'hDEADBEEF;
      write_enabled = 1'b1;
      write_addr    = 5'(k);
      write_data    = v;
      tick();
      total++;
      if (dut.register_file[k] !== v || finish !== 1'b1) begin
        bad++;
        $display("FAIL write_sweep r%0d got=%h finish=%b want=%h finish=1", k, dut.register_file[k], finish, v);
      end
      $display("write r%0d <= %h", k, v);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    write_enabled = 1'b1;
    write_addr    = 5'd0;
    write_data    = 32'hDEADBEEF;
    read_addr_s   = 5'd0;
    tick();
    idle_inputs();
    total++;
    if (outA !== 32'h0 || dut.register_file[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_reg outA=%h stored=%h want=0", outA, dut.register_file[0]);
    end
    $display("zero_reg: write to r0 dropped");
  endtask

  task automatic test_read_sweep();
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      read_addr_s = 5'(a);
      #1;
      total++;
      if (outA !== ref_read(5'(a))) begin
        bad++;
        $display("FAIL read_sweep_s addr=%0d got=%h want=%h", a, outA, ref_read(5'(a)));
      end
      tick();
      total++;
      if (finish !== 1'b0) begin
        bad++;
        $display("FAIL read_sweep_finish got=%b want=0", finish);
      end
    end
    for (int a = 0; a < 32; a++) begin
      read_addr_t = 5'(a);
      #1;
      total++;
      if (outB !== ref_read(5'(a))) begin
        bad++;
        $display("FAIL read_sweep_t addr=%0d got=%h want=%h", a, outB, ref_read(5'(a)));
      end
      tick();
    end
    $display("read_sweep: both ports swept");
  endtask

  task automatic test_hazard();
    read_addr_s   = 5'd5;
    read_addr_t   = 5'd5;
    write_enabled = 1'b1;
    write_addr    = 5'd5;
    write_data    = 32'h12345678;
    #1;
    total++;
    if (outA !== 32'h44444444 || outB !== 32'h44444444) begin
      bad++;
      $display("FAIL hazard_before outA=%h outB=%h want=44444444", outA, outB);
    end
    tick();
    idle_inputs();
    total++;
    if (outA !== 32'h12345678 || outB !== 32'h12345678) begin
      bad++;
      $display("FAIL hazard_after outA=%h outB=%h want=12345678", outA, outB);
    end
    $display("hazard: r5 old/new observed");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      read_enabled  = 1'($urandom_range(0, 1));
      write_enabled = 1'($urandom_range(0, 1));
      write_addr    = 5'($urandom_range(0, 31));
      write_data    = $urandom;
      read_addr_s   = 5'($urandom_range(0, 31));
      read_addr_t   = (n % 4 == 0) ? read_addr_s : 5'($urandom_range(0, 31));
      #1;
      total++;
      if (outA !== ref_read(read_addr_s) || outB !== ref_read(read_addr_t)) begin
        bad++;
        $display("FAIL random_read s=%0d t=%0d outA=%h outB=%h want=%h/%h",
                 read_addr_s, read_addr_t, outA, outB, ref_read(read_addr_s), ref_read(read_addr_t));
      end
      tick();
      total++;
      if (finish !== exp_finish) begin
        bad++;
        $display("FAIL random_finish got=%b want=%b", finish, exp_finish);
      end
    end
    idle_inputs();
    $display("random: 300 cycles");
  endtask

  task automatic test_back_to_back_finish();
    read_enabled = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (finish !== 1'b1) begin
        bad++;
        $display("FAIL back_to_back_finish got=%b want=1", finish);
      end
    end
    read_enabled = 1'b0;
    tick();
    total++;
    if (finish !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_drop got=%b want=0", finish);
    end
    $display("back_to_back: finish held then dropped");
  endtask

  task automatic test_reset_mid();
    write_enabled = 1'b1;
    read_enabled  = 1'b1;
    write_addr    = 5'd7;
    write_data    = 32'hCAFEF00D;
    reset         = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    total++;
    if (dut.register_file[7] !== 32'h0 || finish !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid r7=%h finish=%b want=0/0", dut.register_file[7], finish);
    end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (dut.register_file[k] !== model[k]) begin
        bad++;
        $display("FAIL reset_mid_clear r%0d got=%h want=%h", k, dut.register_file[k], model[k]);
      end
    end
    $display("reset_mid: reset beat write to r7");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_finish = 1'b0;
    test_reset();
    test_write_sweep();
    test_zero_reg();
    test_read_sweep();
    test_hazard();
    test_random();
    test_back_to_back_finish();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf32.md
Name: rf32

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS datapath.
- Two independent combinational read ports (s and t) and one synchronous write port.
- Sits between instruction decode (register addresses) and the ALU/write-back stage.
- Register 0 is hardwired to zero (MIPS convention).
- Also provides a one-cycle `finish` acknowledge for accepted read/write requests.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH = 32.
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all registers and `finish`.
- read_enabled  in  1  read-request strobe; only affects `finish`.
- read_addr_s  in  5  port-A (rs) read address.
- read_addr_t  in  5  port-B (rt) read address.
- write_enabled  in  1  write strobe, sampled on the rising edge.
- write_addr  in  5  write address.
- write_data  in  32  write data.
- outA  out  32  contents of register[read_addr_s].
- outB  out  32  contents of register[read_addr_t].
- finish  out  1  registered acknowledge of a request sampled the previous cycle.

Behaviour:
- Storage: internal array named `register_file[0:31]` of 32-bit registers. The name is fixed so benches can probe it hierarchically.
- Reset, taking effect on the rising edge while reset=1:
  - all 32 entries become 0;
  - `finish` becomes 0;
  - reset has priority over a simultaneous write;
  - after reset, outA/outB read 0 for every address.
- Write, on a rising edge with reset=0 and write_enabled=1:
  - `register_file[write_addr]` takes write_data;
  - if ZERO_REG=1 and write_addr=0, the write is dropped.
  - With write_enabled=0, all registers hold.
- Read:
  - outA and outB are purely combinational muxes of the current array contents.
  - Zero cycles of latency; independent of read_enabled and clock.
  - Address 0 reads 0 when ZERO_REG=1.
- Read/write to the same address in the same cycle:
  - before the edge, the output shows the old value (no write-through bypass);
  - after the edge, the output shows the new value.
- Both read ports may address the same register simultaneously; both return the same value.
- finish:
  - register updated each edge to (read_enabled | write_enabled) when reset=0;
  - so it is high for exactly the cycle after each accepted request;
  - stays high across back-to-back requests.
- Out-of-range addresses do not exist (5-bit address covers all 32 entries).
- No X propagation requirement: outputs are never X after the first reset.

Decomposition:
- Shared package `rf32_pkg` holds:
  - DATA_WIDTH and ADDR_WIDTH constants;
  - typedef `rf_addr_t` (logic [4:0]);
  - typedef `rf_data_t` (logic [31:0]).
- One natural sub-module, `rf32_read_port`: combinational 32:1 mux with zero-register masking, instantiated twice (s and t).
- The write/reset logic and the `finish` flop live in the top level.

Test Plan:
- Reset: hold reset=1 for 1 edge, then sweep read_addr_s=0..30 (even) and read_addr_t=1..31 (odd). Required: outA=outB=32'h0 for all; finish=0.
- Write sweep: write_enabled=1, one write per cycle:
  - r1=32'h00000000, r2=32'h11111111, ... r15=32'hEEEEEEEE, r16=32'hFFFFFFFF, r17..r30=32'h1..32'hE, r31=32'hDEADBEEF.
  - Required: register_file[k] holds each value on the edge after its write; finish=1 the cycle after each write.
- Zero register: write 32'hDEADBEEF to address 0. Required: outA with read_addr_s=0 reads 32'h0; register_file[0]=0.
- Read sweeps with read_enabled=0, write_enabled=0:
  - step read_addr_s 0..31 each cycle: outA matches the written values combinationally;
  - repeat on read_addr_t/outB;
  - finish=0 throughout.
- Same-address hazard: read_addr_s=read_addr_t=write_addr=5 with r5=32'h44444444; write 32'h12345678. Required: both outputs read 44444444 before the edge and 12345678 after it.
- Reset mid-operation: assert reset in the same cycle as a write of 32'hCAFEF00D to r7. Required: r7=0 after the edge, all registers 0, finish=0.
